// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default constants for the memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
  localparam int DEF_STARVE_MAX = 4;
  localparam int DEF_TIMEOUT = 255;
endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: data-first priority with a starvation override for pending fetches
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int SC_W = $clog2(STARVE_MAX + 1)
) (
  input  logic            i_req,
  input  logic            d_req,
  input  logic [SC_W-1:0] starve_cnt,
  output logic            grant_i,
  output logic            grant_d
);
  assign grant_d = d_req && !(i_req && starve_cnt == SC_W'(STARVE_MAX));
  assign grant_i = i_req && !grant_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one busy-signalling RAM between fetch and data ports
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_ren,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_busy,
  output logic              err
);
  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam int WC_W = $clog2(TIMEOUT + 1);
  arb_state_t state, state_nx;
  owner_t owner;
  logic wr, grant_i, grant_d, grant, timeout;
  logic [SC_W-1:0] starve_cnt;
  logic [WC_W-1:0] wait_cnt;
  arb_pick #(.STARVE_MAX(STARVE_MAX), .SC_W(SC_W)) u_pick (
    .i_req(i_req),
    .d_req(d_ren | d_wen),
    .starve_cnt(starve_cnt),
    .grant_i(grant_i),
    .grant_d(grant_d)
  );
  assign grant = state == IDLE && (grant_i || grant_d);
  // Last busy WAIT cycle before wait_cnt hits TIMEOUT abandons the access
  assign timeout = state == WAIT && ram_busy && wait_cnt == WC_W'(TIMEOUT - 1);
  // State register
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) state <= IDLE;
    else state <= state_nx;
  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = grant ? ISSUE : IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = !ram_busy ? DONE : timeout ? IDLE : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  // Strobes and ready pulses decoded from state and latched request kind
  always_comb begin
    ram_ren = state == ISSUE && !wr;
    ram_wen = state == ISSUE && wr;
    i_ready = state == DONE && owner == OWN_I;
    d_ready = state == DONE && owner == OWN_D;
  end
  // Grant latches, starvation and wait counters, read-data capture, err pulse
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      owner      <= OWN_I;
      wr         <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      err        <= 1'b0;
    end else begin
      err <= timeout;
      if (grant) begin
        owner      <= grant_d ? OWN_D : OWN_I;
        wr         <= grant_d && d_wen;
        ram_addr   <= grant_d ? d_addr : i_addr;
        ram_wdata  <= d_wdata;
        starve_cnt <= !(grant_d && i_req) ? '0 :
                      starve_cnt == SC_W'(STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1;
      end
      if (state == ISSUE) wait_cnt <= '0;
      if (state == WAIT && ram_busy) wait_cnt <= wait_cnt + 1'b1;
      if (state == WAIT && !ram_busy && !wr && owner == OWN_D) d_rdata <= ram_rdata;
      if (state == WAIT && !ram_busy && !wr && owner == OWN_I) i_rdata <= ram_rdata;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a busy RAM model
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  localparam int TO = 8;
  typedef struct {
    bit          own_d;
    logic [31:0] addr;
    bit          wr;
    logic [31:0] wdata;
  } acc_t;
  logic clk = 1'b0, nrst = 1'b0;
  logic i_req, i_ready, d_ren, d_wen, d_ready, ram_ren, ram_wen, ram_busy, err;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, ram_addr, ram_wdata, ram_rdata, rd_q;
  acc_t exp_q[$], rdy_q[$], cur;
  int n_cmp = 0, n_bad = 0, cyc = 0, busy_len = 0, busy_left = 0;
  int strobe_cyc = 0, rdy_cyc = 0, err_cyc = 0, n_strobe = 0, n_rdy = 0, n_dready = 0, n_err = 0;
  int i_left = 0, d_left = 0, t0, s0, e0, r0;
  bit stuck = 1'b0;
  logic [31:0] exp_d_last = '0;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .nrst(nrst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_ren(ram_ren), .ram_wen(ram_wen),
    .ram_rdata(ram_rdata), .ram_busy(ram_busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ram_f(input logic [31:0] a);
    return a == 32'h10 ? 32'h00500093 : {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  // RAM model: busy for busy_len cycles after each strobe, garbage data while busy
  assign ram_busy = stuck || busy_left != 0;
  assign ram_rdata = ram_busy ? 32'hBAD0BAD0 : rd_q;
  always @(posedge clk or negedge nrst)
    if (!nrst) begin
      busy_left <= 0;
      rd_q <= '0;
    end else if (ram_ren || ram_wen) begin
      busy_left <= busy_len;
      rd_q <= ram_f(ram_addr);
    end else if (busy_left != 0) busy_left <= busy_left - 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit own_d, input logic [31:0] addr, input bit wr, input logic [31:0] wdata);
    acc_t a;
    a.own_d = own_d; a.addr = addr; a.wr = wr; a.wdata = wdata;
    exp_q.push_back(a);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_i_rdata"}, i_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    chk({tag, "_ram_addr"}, ram_addr, 32'd0);
    chk({tag, "_ram_wdata"}, ram_wdata, 32'd0);
    chk({tag, "_pulses"}, 32'({i_ready, d_ready, ram_ren, ram_wen, err}), 32'd0);
    chk({tag, "_state"}, 32'(dut.state), 32'(IDLE));
    chk({tag, "_starve"}, 32'(dut.starve_cnt), 32'd0);
    chk({tag, "_wait_cnt"}, 32'(dut.wait_cnt), 32'd0);
  endtask

  // Drive held requests until their ready pulses arrive, bounded by budget
  task automatic run(input int budget);
    int n = 0;
    bit gi, gd;
    while ((i_req || d_ren || d_wen) && n < budget) begin
      @(negedge clk);
      n++;
      gi = i_ready;
      gd = d_ready;
      @(posedge clk);
      #1;
      if (gi && i_left > 0) begin
        i_left--;
        if (i_left == 0) i_req = 1'b0;
      end
      if (gd && d_left > 0) begin
        d_left--;
        if (d_left == 0) begin
          d_ren = 1'b0;
          d_wen = 1'b0;
        end else begin
          d_addr += 32'd4;
          d_wdata += 32'd1;
        end
      end
    end
    chk("requests_served", 32'(i_req || d_ren || d_wen), 32'd0);
  endtask

  // Scoreboard monitor: strobes pop the expected-access queue, readies pop the in-flight queue
  always @(negedge clk) if (nrst) begin
    if (ram_ren || ram_wen) begin
      n_strobe++;
      strobe_cyc = cyc;
      chk("access_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        cur = exp_q.pop_front();
        chk("ram_addr", ram_addr, cur.addr);
        chk("ram_wen", 32'(ram_wen), 32'(cur.wr));
        chk("ram_ren", 32'(ram_ren), 32'(!cur.wr));
        if (cur.wr) chk("ram_wdata", ram_wdata, cur.wdata);
        rdy_q.push_back(cur);
      end
    end else if (ram_busy && rdy_q.size() != 0) begin
      chk("hold_addr", ram_addr, cur.addr);
      if (cur.wr) chk("hold_wdata", ram_wdata, cur.wdata);
    end
    if (i_ready || d_ready) begin
      acc_t r;
      n_rdy++;
      rdy_cyc = cyc;
      if (d_ready) n_dready++;
      chk("ready_expected", 32'(rdy_q.size() != 0), 32'd1);
      if (rdy_q.size() != 0) begin
        r = rdy_q.pop_front();
        chk("ready_owner", 32'({i_ready, d_ready}), r.own_d ? 32'd1 : 32'd2);
        chk("ready_latency", 32'(cyc - strobe_cyc), 32'(busy_len + 2));
        if (!r.own_d) chk("i_rdata", i_rdata, ram_f(r.addr));
        else if (!r.wr) begin
          exp_d_last = ram_f(r.addr);
          chk("d_rdata", d_rdata, exp_d_last);
        end else chk("d_rdata_kept", d_rdata, exp_d_last);
        if (i_ready) chk("starve_after_fetch", 32'(dut.starve_cnt), 32'd0);
      end
    end
    if (err) begin
      n_err++;
      err_cyc = cyc;
    end
  end

  initial begin
    i_req = 0; d_ren = 0; d_wen = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    nrst = 1'b1;
    @(posedge clk);
    #1;
    // single fetch
    push(0, 32'h10, 0, 0);
    i_req = 1; i_addr = 32'h10; i_left = 1; t0 = cyc;
    run(20);
    chk("fetch_strobe_cycle", 32'(strobe_cyc - t0), 32'd1);
    chk("fetch_ready_cycle", 32'(rdy_cyc - t0), 32'd3);
    chk("fetch_no_d_ready", 32'(n_dready), 32'd0);
    // simultaneous fetch and load: data first
    push(1, 32'h24, 0, 0);
    push(0, 32'h30, 0, 0);
    i_req = 1; i_addr = 32'h30; i_left = 1;
    d_ren = 1; d_addr = 32'h24; d_left = 1;
    run(40);
    // starvation: four data grants, then the fetch, then the remaining store
    for (int k = 0; k < 4; k++) push(1, 32'h100 + 32'(4 * k), 1, 32'(k + 1));
    push(0, 32'h200, 0, 0);
    push(1, 32'h110, 1, 32'd5);
    i_req = 1; i_addr = 32'h200; i_left = 1;
    d_wen = 1; d_addr = 32'h100; d_wdata = 32'd1; d_left = 5;
    run(100);
    chk("starve_end", 32'(dut.starve_cnt), 32'd0);
    // store with a 5-cycle busy RAM
    busy_len = 5;
    push(1, 32'h08, 1, 32'hDEADBEEF);
    d_wen = 1; d_addr = 32'h08; d_wdata = 32'hDEADBEEF; d_left = 1;
    run(40);
    busy_len = 0;
    // timeout with RAM stuck busy; request dropped once granted
    stuck = 1;
    push(0, 32'h40, 0, 0);
    i_req = 1; i_addr = 32'h40; s0 = n_strobe; e0 = n_err; r0 = n_rdy;
    for (int k = 0; k < 10 && n_strobe == s0; k++) @(posedge clk);
    #1;
    i_req = 0;
    chk("timeout_strobe", 32'(n_strobe - s0), 32'd1);
    repeat (TO + 4) @(posedge clk);
    #1;
    chk("err_pulses", 32'(n_err - e0), 32'd1);
    chk("err_cycle", 32'(err_cyc - strobe_cyc), 32'(TO + 1));
    chk("timeout_no_ready", 32'(n_rdy - r0), 32'd0);
    chk("timeout_idle", 32'(dut.state), 32'(IDLE));
    chk("timeout_abandoned", 32'(rdy_q.size()), 32'd1);
    rdy_q.delete();
    stuck = 0;
    push(0, 32'h44, 0, 0);
    i_req = 1; i_addr = 32'h44; i_left = 1;
    run(20);
    // asynchronous reset in the middle of WAIT
    busy_len = 10;
    push(0, 32'h50, 0, 0);
    i_req = 1; i_addr = 32'h50; i_left = 1; s0 = n_strobe;
    for (int k = 0; k < 10 && n_strobe == s0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #3;
    nrst = 1'b0;
    #1;
    chk_zero("rst_mid");
    rdy_q.delete();
    busy_len = 0;
    r0 = n_rdy;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    push(0, 32'h50, 0, 0);
    run(20);
    chk("regrant_ready", 32'(n_rdy - r0), 32'd1);
    chk("queues_drained", 32'(exp_q.size() + rdy_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
